// File: rtl/control_fsm.sv
// Multicycle RV32I control sequencer.
// Moore stage register; strobes decoded from stage and IR.
module control_fsm #(
  parameter logic [4:0] TRAP_STAGE = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_reg,
  input  logic        branch_taken,
  output logic [4:0]  current_stage,
  output logic        IRWrite_reg,
  output logic        IorD_reg,
  output logic        MemWrite_reg,
  output logic [3:0]  AluControl_reg,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        illegal
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_EXEC_R   = 5'd3,
    S_EXEC_I   = 5'd4,
    S_MEMREAD  = 5'd5,
    S_MEMWB    = 5'd6,
    S_ALUWB    = 5'd7,
    S_BRANCH   = 5'd8,
    S_MEMWRITE = 5'd9,
    S_JAL      = 5'd10,
    S_JALR     = 5'd11,
    S_LUI      = 5'd12,
    S_AUIPC    = 5'd13
  } stage_e;

  logic [4:0] stage_q;
  logic [4:0] stage_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir;

  assign opcode    = instruction_reg[6:0];
  assign funct3    = instruction_reg[14:12];
  assign funct7    = instruction_reg[31:25];
  assign unused_ir = ^{instruction_reg[24:15], instruction_reg[11:7]};

  // funct3 plus alternate bit to ALU operation code
  function automatic logic [3:0] alu_code(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] c;
    c = 4'b0000;
    case (f3)
      3'b000:  c = alt ? 4'b0001 : 4'b0000;
      3'b001:  c = 4'b0010;
      3'b010:  c = 4'b0011;
      3'b011:  c = 4'b0100;
      3'b100:  c = 4'b0101;
      3'b101:  c = alt ? 4'b0111 : 4'b0110;
      3'b110:  c = 4'b1011;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  logic load_ok;
  logic store_ok;
  logic r_f7_ok;
  logic i_f7_ok;

  // Legality of funct3/funct7 for the opcode in the IR
  always_comb begin
    load_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b010) || (funct3 == 3'b100) ||
               (funct3 == 3'b101);
    store_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b010);
    r_f7_ok  = (funct7 == 7'b0000000) ||
               ((funct7 == 7'b0100000) &&
                ((funct3 == 3'b000) || (funct3 == 3'b101)));
    i_f7_ok  = 1'b1;
    if (funct3 == 3'b001)
      i_f7_ok = (funct7 == 7'b0000000);
    else if (funct3 == 3'b101)
      i_f7_ok = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000);
  end

  // Next stage and Moore outputs, reset gating applied last
  always_comb begin
    stage_d        = TRAP_STAGE;
    IRWrite_reg    = 1'b0;
    IorD_reg       = 1'b0;
    MemWrite_reg   = 1'b0;
    AluControl_reg = 4'b0000;
    pc_write       = 1'b0;
    reg_write      = 1'b0;
    wb_sel         = 2'd0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'd0;
    illegal        = 1'b0;
    case (stage_q)
      S_FETCH: begin
        IRWrite_reg = 1'b1;
        alu_src_b   = 2'd2;
        pc_write    = 1'b1;
        stage_d     = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          7'b0000011:
            stage_d = load_ok ? S_MEMADR : TRAP_STAGE;
          7'b0100011:
            stage_d = store_ok ? S_MEMADR : TRAP_STAGE;
          7'b0110011: stage_d = S_EXEC_R;
          7'b0010011: stage_d = S_EXEC_I;
          7'b1100011: stage_d = S_BRANCH;
          7'b1101111: stage_d = S_JAL;
          7'b1100111: stage_d = S_JALR;
          7'b0110111: stage_d = S_LUI;
          7'b0010111: stage_d = S_AUIPC;
          default:    stage_d = TRAP_STAGE;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd1;
        stage_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD_reg       = 1'b1;
        AluControl_reg = {1'b1, funct3};
        stage_d        = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
        stage_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD_reg       = 1'b1;
        MemWrite_reg   = 1'b1;
        AluControl_reg = {1'b1, funct3};
        stage_d        = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a      = 1'b1;
        alu_src_b      = 2'd0;
        AluControl_reg = alu_code(funct3, instruction_reg[30]);
        stage_d        = r_f7_ok ? S_ALUWB : TRAP_STAGE;
      end
      S_EXEC_I: begin
        alu_src_a      = 1'b1;
        alu_src_b      = 2'd1;
        AluControl_reg = alu_code(funct3,
          instruction_reg[30] && (funct3 == 3'b101));
        stage_d        = i_f7_ok ? S_ALUWB : TRAP_STAGE;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        wb_sel    = 2'd0;
        stage_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a      = 1'b1;
        alu_src_b      = 2'd0;
        AluControl_reg = 4'b0001;
        pc_write       = branch_taken;
        stage_d        = S_FETCH;
      end
      S_JAL: begin
        alu_src_b = 2'd1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        pc_write  = 1'b1;
        stage_d   = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        pc_write  = 1'b1;
        stage_d   = S_FETCH;
      end
      S_LUI: begin
        reg_write = 1'b1;
        wb_sel    = 2'd0;
        stage_d   = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_b = 2'd1;
        reg_write = 1'b1;
        wb_sel    = 2'd0;
        stage_d   = S_FETCH;
      end
      default: begin
        stage_d = TRAP_STAGE;
        illegal = (stage_q == TRAP_STAGE);
      end
    endcase
    if (!reset) begin
      IRWrite_reg  = 1'b0;
      MemWrite_reg = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
    end
  end

  // Stage register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) stage_q <= S_FETCH;
    else        stage_q <= stage_d;
  end

  assign current_stage = stage_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm.
// Hand-computed stage walks and strobe checks.
module tb_control_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] instruction_reg;
  logic        branch_taken;
  logic [4:0]  current_stage;
  logic        IRWrite_reg;
  logic        IorD_reg;
  logic        MemWrite_reg;
  logic [3:0]  AluControl_reg;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        illegal;

  int vectors = 0;
  int errors  = 0;

  control_fsm #(.TRAP_STAGE(5'd31)) dut (
    .clk            (clk),
    .reset          (reset),
    .instruction_reg(instruction_reg),
    .branch_taken   (branch_taken),
    .current_stage  (current_stage),
    .IRWrite_reg    (IRWrite_reg),
    .IorD_reg       (IorD_reg),
    .MemWrite_reg   (MemWrite_reg),
    .AluControl_reg (AluControl_reg),
    .pc_write       (pc_write),
    .reg_write      (reg_write),
    .wb_sel         (wb_sel),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(
    input logic [6:0] f7,
    input logic [2:0] f3,
    input logic [6:0] op
  );
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    branch_taken    = 1'b0;
    instruction_reg = mk(7'd0, 3'b010, 7'b0000011);
    tick();
    chk("rst_stage", current_stage, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_pcw", pc_write, 0);
    chk("rst_irw", IRWrite_reg, 0);
    reset = 1'b1;
    #1;
    // lw
    chk("lw_f_irw", IRWrite_reg, 1);
    chk("lw_f_pcw", pc_write, 1);
    chk("lw_f_srcb", alu_src_b, 2);
    chk("lw_f_iord", IorD_reg, 0);
    tick();
    chk("lw_s1", current_stage, 1);
    chk("lw_d_pcw", pc_write, 0);
    tick();
    chk("lw_s2", current_stage, 2);
    chk("lw_ma_a", alu_src_a, 1);
    chk("lw_ma_b", alu_src_b, 1);
    chk("lw_ma_alu", AluControl_reg, 0);
    tick();
    chk("lw_s5", current_stage, 5);
    chk("lw_mr_alu", AluControl_reg, 4'b1010);
    chk("lw_mr_iord", IorD_reg, 1);
    chk("lw_mr_rw", reg_write, 0);
    tick();
    chk("lw_s6", current_stage, 6);
    chk("lw_wb_rw", reg_write, 1);
    chk("lw_wb_sel", wb_sel, 1);
    tick();
    chk("lw_s0", current_stage, 0);
    chk("lw_end_rw", reg_write, 0);
    // sb
    instruction_reg = mk(7'd0, 3'b000, 7'b0100011);
    tick();
    chk("sb_s1", current_stage, 1);
    chk("sb_d_mw", MemWrite_reg, 0);
    tick();
    chk("sb_s2", current_stage, 2);
    chk("sb_ma_mw", MemWrite_reg, 0);
    tick();
    chk("sb_s9", current_stage, 9);
    chk("sb_mw", MemWrite_reg, 1);
    chk("sb_alu", AluControl_reg, 4'b1000);
    chk("sb_rw", reg_write, 0);
    tick();
    chk("sb_s0", current_stage, 0);
    chk("sb_end_mw", MemWrite_reg, 0);
    // beq not taken then taken
    instruction_reg = mk(7'd0, 3'b000, 7'b1100011);
    branch_taken    = 1'b0;
    tick();
    tick();
    chk("beq0_s8", current_stage, 8);
    chk("beq0_pcw", pc_write, 0);
    chk("beq0_alu", AluControl_reg, 4'b0001);
    tick();
    chk("beq0_s0", current_stage, 0);
    branch_taken = 1'b1;
    tick();
    tick();
    chk("beq1_s8", current_stage, 8);
    chk("beq1_pcw", pc_write, 1);
    tick();
    chk("beq1_s0", current_stage, 0);
    branch_taken = 1'b0;
    // sub
    instruction_reg = mk(7'b0100000, 3'b000, 7'b0110011);
    tick();
    tick();
    chk("sub_s3", current_stage, 3);
    chk("sub_alu", AluControl_reg, 4'b0001);
    chk("sub_b", alu_src_b, 0);
    chk("sub_rw3", reg_write, 0);
    tick();
    chk("sub_s7", current_stage, 7);
    chk("sub_rw", reg_write, 1);
    chk("sub_sel", wb_sel, 0);
    tick();
    chk("sub_s0", current_stage, 0);
    // srai
    instruction_reg = mk(7'b0100000, 3'b101, 7'b0010011);
    tick();
    tick();
    chk("srai_s4", current_stage, 4);
    chk("srai_alu", AluControl_reg, 4'b0111);
    chk("srai_b", alu_src_b, 1);
    tick();
    chk("srai_s7", current_stage, 7);
    tick();
    // xori with negative immediate: bit30 is immediate
    instruction_reg = mk(7'b1111111, 3'b100, 7'b0010011);
    tick();
    tick();
    chk("xori_alu", AluControl_reg, 4'b0101);
    tick();
    chk("xori_s7", current_stage, 7);
    tick();
    // jal
    instruction_reg = mk(7'd0, 3'b000, 7'b1101111);
    tick();
    tick();
    chk("jal_s10", current_stage, 10);
    chk("jal_rw", reg_write, 1);
    chk("jal_sel", wb_sel, 2);
    chk("jal_pcw", pc_write, 1);
    tick();
    chk("jal_s0", current_stage, 0);
    // jalr
    instruction_reg = mk(7'd0, 3'b000, 7'b1100111);
    tick();
    tick();
    chk("jalr_s11", current_stage, 11);
    chk("jalr_a", alu_src_a, 1);
    chk("jalr_b", alu_src_b, 1);
    tick();
    // lui
    instruction_reg = mk(7'd0, 3'b000, 7'b0110111);
    tick();
    tick();
    chk("lui_s12", current_stage, 12);
    chk("lui_rw", reg_write, 1);
    chk("lui_sel", wb_sel, 0);
    tick();
    chk("lui_s0", current_stage, 0);
    // illegal R funct7 traps without writeback
    instruction_reg = mk(7'b0000001, 3'b000, 7'b0110011);
    tick();
    tick();
    chk("badr_s3", current_stage, 3);
    tick();
    chk("badr_trap", current_stage, 31);
    chk("badr_rw", reg_write, 0);
    chk("badr_ill", illegal, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("badr_rst", current_stage, 0);
    // store with funct3 011 traps from DECODE
    instruction_reg = mk(7'd0, 3'b011, 7'b0100011);
    tick();
    tick();
    chk("badst_trap", current_stage, 31);
    chk("badst_mw", MemWrite_reg, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("badst_rst", current_stage, 0);
    // unknown opcode, trap is held
    instruction_reg = mk(7'd0, 3'b000, 7'b1111111);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("trap_stage", current_stage, 31);
      chk("trap_ill", illegal, 1);
      chk("trap_irw", IRWrite_reg, 0);
      chk("trap_pcw", pc_write, 0);
      tick();
    end
    reset = 1'b0;
    tick();
    chk("trap_rst_s", current_stage, 0);
    chk("trap_rst_i", illegal, 0);
    reset = 1'b1;
    // reset during MEMWRITE aborts the store
    instruction_reg = mk(7'd0, 3'b010, 7'b0100011);
    #1;
    tick();
    tick();
    tick();
    chk("abort_s9", current_stage, 9);
    chk("abort_mw1", MemWrite_reg, 1);
    chk("abort_sw_alu", AluControl_reg, 4'b1010);
    reset = 1'b0;
    #1;
    chk("abort_mw0", MemWrite_reg, 0);
    tick();
    chk("abort_s0", current_stage, 0);
    chk("abort_irw", IRWrite_reg, 0);
    reset = 1'b1;
    #1;
    chk("abort_irw1", IRWrite_reg, 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
